arm_mc_controller: RTL and testbench
====================================

# arm_mc_controller

Multicycle ARM control unit with memory wait-state handshake, a CMP mode and performance counters. It drives the multicycle datapath's mux selects and write enables from Instr[31:12], the ALU flags and a memory ready strobe. It sits between the instruction register and the datapath in the multicycle processor top and replaces the fixed-latency controller.

## Interface
- WAIT_EN, 1: 1 = honour MemReady; 0 = MemReady is ignored and treated as 1.
- CMP_EN, 1: 1 = decode CMP (cmd 1010); 0 = cmd 1010 is illegal.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; everything changes on the rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  20  Instr[31:12] of the instruction register: cond, op, funct, Rd.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- MemReady  in  1  memory has completed the current access.
- RegSrc  out  2  register read-address selects.
- ImmSrc  out  2  extender mode.
- ALUSrcA  out  1  ALU input A select.
- ALUSrcB  out  2  ALU input B select.
- ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ResultSrc  out  2  result mux select.
- AdrSrc  out  1  memory address select.
- RegWrite, MemWrite, PCWrite, IRWrite  out  1 each  write enables.
- Undef  out  1  one-cycle pulse on an illegal instruction.
- InstrRet  out  1  one-cycle pulse when an instruction completes.
- CycleCnt, InstrCnt  out  CNT_W each  free-running counters.

## Operation
Fields used: cond = Instr[31:28], op = Instr[27:26], funct = Instr[25:20], cmd = funct[4:1], S = funct[0].

FSM states and transitions:
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - Holds while MemReady=0.
  - When MemReady=1: IRWrite=1, PCWrite=1, then -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Registers CondEx. Next state:
  - op=01 -> MEMADR.
  - op=00 with legal cmd -> EXECUTER if funct[5]=0, EXECUTEI if funct[5]=1.
  - op=10 -> BRANCH.
  - op=11 or illegal cmd -> pulse Undef, -> FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. -> MEMREAD if S=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds while MemReady=0, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx. Held level while waiting; -> FETCH on MemReady=1.
- EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 / 01, ALU decode. -> ALUWB, or -> FETCH for CMP.
- ALUWB: ResultSrc=00, RegWrite=CondEx. -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. -> FETCH.

Static decodes:
- ImmSrc=op.
- RegSrc[0]=(op==10); RegSrc[1]=(op==01).
- Outputs not listed for a state are 0.

ALU decode:
- Legal cmds: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, and 1010 CMP when CMP_EN=1. Any other cmd with op=00 is illegal.
- FlagW[1]=S; FlagW[0]=S & (ADD|SUB).
- CMP: SUB, no register write, FlagW=11 regardless of S.

Flags register:
- NZ updates from ALUFlags[3:2] when FlagW[1] & CondEx.
- CV updates from ALUFlags[1:0] when FlagW[0] & CondEx.
- Updates happen only in the EXECUTER/EXECUTEI cycle.

Condition check (combinational on the flags register, sampled at the end of DECODE):
- 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
- 1000 C&!Z; 1001 !(C&!Z); 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 !(!Z&(N==V)); 1110 and 1111 always true.

InstrRet:
- Pulses in the final cycle of every legal instruction: the cycle whose next state is FETCH, excluding the Undef case.
- Predicated-off instructions still retire.
- InstrCnt increments on each InstrRet. CycleCnt increments every non-reset cycle. Both wrap modulo 2^CNT_W.

## Timing
Reset (synchronous):
- State=FETCH; flags=0; CondEx=0; counters=0.
- While reset=1, RegWrite, MemWrite, PCWrite, IRWrite, Undef and InstrRet are forced to 0.
- Reset mid-instruction abandons the instruction with no writes. The first FETCH follows the cycle after reset deasserts.

Zero-wait latency in cycles:
- LDR 5, STR 4, data-processing 4, CMP 3, B 3, illegal 2.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds 1.
- With WAIT_EN=0 there are no stalls.

Handshake:
- A memory access completes in the cycle MemReady=1.
- MemReady=1 during a non-memory state is ignored.

## Test plan
- Reset held 3 cycles mid-LDR (e.g. in MEMREAD) -> all enables 0 during reset; FETCH next; CycleCnt=0 and InstrCnt=0 after release.
- ADDS R1 (Instr=0xE0911) with ALUFlags=0110 -> exactly 4 cycles; RegWrite in cycle 4; flags=0110; InstrCnt=1.
- BEQ with Z=0 -> 3 cycles; PCWrite=0 in BRANCH; InstrRet=1. BEQ with Z=1 -> PCWrite=1 in BRANCH.
- LDR with MemReady low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; IRWrite high only in the ready cycle.
- STR with NE condition and Z=1 -> MemWrite never asserted; FSM still waits for MemReady in MEMWRITE.
- CMP (cmd 1010, S=0) with CMP_EN=1 -> 3 cycles, flags updated, no RegWrite. With CMP_EN=0 -> Undef pulse, InstrCnt unchanged. op=11 -> Undef.

Source files
------------

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control FSM with memory wait states,
// optional CMP decode, NZCV flag register and performance counters.
module arm_mc_controller #(
  parameter bit WAIT_EN = 1'b1,
  parameter bit CMP_EN  = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [19:0]      Instr,
  input  logic [3:0]       ALUFlags,
  input  logic             MemReady,
  output logic [1:0]       RegSrc,
  output logic [1:0]       ImmSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUControl,
  output logic [1:0]       ResultSrc,
  output logic             AdrSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             Undef,
  output logic             InstrRet,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstrCnt
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  state_t state;
  state_t next;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       sbit;
  logic       unused_bits;

  assign cond        = Instr[19:16];
  assign op          = Instr[15:14];
  assign funct       = Instr[13:8];
  assign cmd         = funct[4:1];
  assign sbit        = funct[0];
  assign unused_bits = ^Instr[7:0];

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_orr;
  logic is_cmp;
  logic dp_legal;

  assign is_add   = (cmd == 4'b0100);
  assign is_sub   = (cmd == 4'b0010);
  assign is_and   = (cmd == 4'b0000);
  assign is_orr   = (cmd == 4'b1100);
  assign is_cmp   = CMP_EN && (cmd == 4'b1010);
  assign dp_legal = is_add | is_sub | is_and | is_orr | is_cmp;

  logic [1:0] alu_ctl;
  logic [1:0] flag_w;

  always_comb begin
    alu_ctl = 2'b00;
    unique case (1'b1)
      is_add:  alu_ctl = 2'b00;
      is_sub:  alu_ctl = 2'b01;
      is_and:  alu_ctl = 2'b10;
      is_orr:  alu_ctl = 2'b11;
      is_cmp:  alu_ctl = 2'b01;
      default: alu_ctl = 2'b00;
    endcase
  end

  // CMP always writes all four flags, whatever S says
  assign flag_w = is_cmp ? 2'b11 : {sbit, sbit & (is_add | is_sub)};

  logic [3:0] flags;
  logic       condex;
  logic       cond_ok;
  logic       fn;
  logic       fz;
  logic       fc;
  logic       fv;

  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = ~fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = ~fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = ~fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = ~fv;
      4'b1000: cond_ok = fc & ~fz;
      4'b1001: cond_ok = ~(fc & ~fz);
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = ~fz & (fn == fv);
      4'b1101: cond_ok = ~(~fz & (fn == fv));
      default: cond_ok = 1'b1;
    endcase
  end

  logic mem_ok;

  assign mem_ok = WAIT_EN ? MemReady : 1'b1;

  logic rw_c;
  logic mw_c;
  logic pcw_c;
  logic irw_c;
  logic undef_c;
  logic ret_c;

  always_comb begin
    next       = state;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    rw_c       = 1'b0;
    mw_c       = 1'b0;
    pcw_c      = 1'b0;
    irw_c      = 1'b0;
    undef_c    = 1'b0;
    unique case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ok) begin
          irw_c = 1'b1;
          pcw_c = 1'b1;
          next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (op)
          2'b01: next = S_MEMADR;
          2'b10: next = S_BRANCH;
          2'b00: begin
            if (dp_legal) begin
              next = funct[5] ? S_EXECI : S_EXECR;
            end else begin
              undef_c = 1'b1;
              next    = S_FETCH;
            end
          end
          default: begin
            undef_c = 1'b1;
            next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        next    = sbit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ok) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_c      = condex;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw_c   = condex;
        if (mem_ok) next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        next       = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        rw_c = condex;
        next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw_c     = condex;
        next      = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

  // FETCH waiting on memory also loops back to FETCH; that is not a retire
  assign ret_c = (state != S_FETCH) && (next == S_FETCH) && !undef_c;

  assign ImmSrc    = op;
  assign RegSrc    = {op == 2'b01, op == 2'b10};
  assign RegWrite  = rw_c & ~reset;
  assign MemWrite  = mw_c & ~reset;
  assign PCWrite   = pcw_c & ~reset;
  assign IRWrite   = irw_c & ~reset;
  assign Undef     = undef_c & ~reset;
  assign InstrRet  = ret_c & ~reset;

  logic in_exec;

  assign in_exec = (state == S_EXECR) || (state == S_EXECI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      flags  <= 4'b0000;
      condex <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE) condex <= cond_ok;
      if (in_exec && condex && flag_w[1]) flags[3:2] <= ALUFlags[3:2];
      if (in_exec && condex && flag_w[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + CNT_W'(1);
      if (ret_c) InstrCnt <= InstrCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: scenario tasks plus randomized instruction stream
// checked against an instruction-level model of the controller.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        MemReady = 1'b0;

  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic        ALUSrcA, AdrSrc, RegWrite, MemWrite, PCWrite, IRWrite;
  logic        Undef, InstrRet;
  logic [31:0] CycleCnt, InstrCnt;

  logic [1:0]  x_RegSrc, x_ImmSrc, x_ALUSrcB, x_ALUControl, x_ResultSrc;
  logic        x_ALUSrcA, x_AdrSrc, x_RegWrite, x_MemWrite, x_PCWrite;
  logic        x_IRWrite, x_Undef, x_InstrRet;
  logic [31:0] x_CycleCnt, x_InstrCnt;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .Undef(Undef), .InstrRet(InstrRet), .CycleCnt(CycleCnt),
    .InstrCnt(InstrCnt)
  );

  arm_mc_controller #(.WAIT_EN(1'b0), .CMP_EN(1'b0)) dut_x (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .RegSrc(x_RegSrc), .ImmSrc(x_ImmSrc),
    .ALUSrcA(x_ALUSrcA), .ALUSrcB(x_ALUSrcB), .ALUControl(x_ALUControl),
    .ResultSrc(x_ResultSrc), .AdrSrc(x_AdrSrc), .RegWrite(x_RegWrite),
    .MemWrite(x_MemWrite), .PCWrite(x_PCWrite), .IRWrite(x_IRWrite),
    .Undef(x_Undef), .InstrRet(x_InstrRet), .CycleCnt(x_CycleCnt),
    .InstrCnt(x_InstrCnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_LDR, K_STR, K_DP, K_CMP, K_B, K_UND} kind_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_flags;
  int         m_cycles;
  int         m_instrs;

  int  o_cycles, o_irw, o_irw_cyc, o_rw, o_rw_cyc, o_mw, o_pcw;
  int  o_undef, o_ret;
  logic [1:0] o_aluc, o_srcb;
  bit  o_timeout;

  int  e_cycles, e_rw, e_mw, e_pcw, e_undef, e_ret;
  logic [1:0] e_aluc, e_srcb;
  logic [3:0] e_flags;
  bit  e_alu_chk, e_mem;

  function automatic kind_t classify(logic [19:0] ins, bit cmp_en);
    logic [1:0] op  = ins[15:14];
    logic [3:0] cmd = ins[12:9];
    if (op == 2'b01) return ins[8] ? K_LDR : K_STR;
    if (op == 2'b10) return K_B;
    if (op == 2'b11) return K_UND;
    if (cmd == 4'b1010) return cmp_en ? K_CMP : K_UND;
    if (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100}) return K_DP;
    return K_UND;
  endfunction

  function automatic bit cond_holds(logic [3:0] c, logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic void predict(logic [19:0] ins, logic [3:0] af,
                                  int wf, int wm);
    kind_t k = classify(ins, 1'b1);
    bit ce = cond_holds(ins[19:16], m_flags);
    logic [3:0] cmd = ins[12:9];
    bit s = ins[8];
    int base;
    case (k)
      K_LDR: base = 5;
      K_STR: base = 4;
      K_DP:  base = 4;
      K_CMP: base = 3;
      K_B:   base = 3;
      default: base = 2;
    endcase
    e_mem     = (k == K_LDR) || (k == K_STR);
    e_cycles  = base + wf + (e_mem ? wm : 0);
    e_rw      = ((k == K_LDR || k == K_DP) && ce) ? 1 : 0;
    e_mw      = (k == K_STR && ce) ? wm + 1 : 0;
    e_pcw     = (k == K_B && ce) ? 2 : 1;
    e_undef   = (k == K_UND) ? 1 : 0;
    e_ret     = (k == K_UND) ? 0 : 1;
    e_alu_chk = (k == K_DP) || (k == K_CMP);
    e_srcb    = ins[13] ? 2'b01 : 2'b00;
    case (cmd)
      4'b0100: e_aluc = 2'b00;
      4'b0010: e_aluc = 2'b01;
      4'b0000: e_aluc = 2'b10;
      4'b1100: e_aluc = 2'b11;
      default: e_aluc = 2'b01;
    endcase
    e_flags = m_flags;
    if (e_alu_chk && ce) begin
      if (k == K_CMP || s) e_flags[3:2] = af[3:2];
      if (k == K_CMP || (s && (cmd == 4'b0100 || cmd == 4'b0010)))
        e_flags[1:0] = af[1:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) m_cycles++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_flags = 4'h0;
    m_cycles = 0;
    m_instrs = 0;
  endtask

  task automatic commit();
    m_flags = e_flags;
    m_instrs += e_ret;
  endtask

  // Drives one instruction from FETCH to its final cycle and records
  // what the controller did; MemReady is random where it should be ignored.
  task automatic run_instr(logic [19:0] ins, logic [3:0] af,
                           int wf, int wm, bit is_mem);
    bit done = 0;
    o_cycles = 0; o_irw = 0; o_irw_cyc = -1; o_rw = 0; o_rw_cyc = -1;
    o_mw = 0; o_pcw = 0; o_undef = 0; o_ret = 0;
    o_aluc = 2'bxx; o_srcb = 2'bxx;
    Instr = ins;
    ALUFlags = af;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c < wf) MemReady = 1'b0;
      else if (c == wf) MemReady = 1'b1;
      else if (is_mem && c >= wf + 3 && c < wf + 3 + wm) MemReady = 1'b0;
      else if (is_mem && c == wf + 3 + wm) MemReady = 1'b1;
      else MemReady = 1'($urandom);
      #1;
      if (IRWrite) begin o_irw++; o_irw_cyc = c; end
      if (RegWrite) begin o_rw++; o_rw_cyc = c; end
      if (MemWrite) o_mw++;
      if (PCWrite) o_pcw++;
      if (Undef) o_undef++;
      if (InstrRet) o_ret++;
      if (c == wf + 2) begin o_aluc = ALUControl; o_srcb = ALUSrcB; end
      if (InstrRet || Undef) begin done = 1; o_cycles = c + 1; end
      tick();
    end
    o_timeout = !done;
  endtask

  localparam logic [19:0] ADDS_R1 = 20'hE0911;
  localparam logic [19:0] ADD_R2  = 20'hE0812;
  localparam logic [19:0] LDR_I   = 20'hE5921;
  localparam logic [19:0] STR_NE  = 20'h15821;
  localparam logic [19:0] CMP_I   = 20'hE1410;
  localparam logic [19:0] BEQ_I   = 20'h0A000;
  localparam logic [19:0] BCS_I   = 20'h2A000;
  localparam logic [19:0] BVS_I   = 20'h6A000;
  localparam logic [19:0] BMI_I   = 20'h4A000;
  localparam logic [19:0] OP11_I  = 20'hEC000;

  task automatic test_reset();
    do_reset();
    Instr = LDR_I;
    MemReady = 1'b1;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    tick();
    reset = 1'b1;
    MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({RegWrite, MemWrite, PCWrite, IRWrite, Undef, InstrRet} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_enables cyc%0d: got %b required 000000", i,
                 {RegWrite, MemWrite, PCWrite, IRWrite, Undef, InstrRet});
      end
      tick();
    end
    reset = 1'b0;
    m_flags = 4'h0; m_cycles = 0; m_instrs = 0;
    #1;
    n_cmp++;
    if (CycleCnt !== 32'd0) begin
      n_bad++; $display("FAIL reset_cyclecnt: got %0d required 0", CycleCnt);
    end
    n_cmp++;
    if (InstrCnt !== 32'd0) begin
      n_bad++; $display("FAIL reset_instrcnt: got %0d required 0", InstrCnt);
    end
    predict(ADD_R2, 4'h0, 0, 0);
    run_instr(ADD_R2, 4'h0, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_irw_cyc !== 0 || o_cycles !== 4) begin
      n_bad++;
      $display("FAIL reset_first_fetch: irw_cyc %0d cycles %0d required 0 4",
               o_irw_cyc, o_cycles);
    end
  endtask

  task automatic test_adds();
    do_reset();
    predict(ADDS_R1, 4'b0110, 0, 0);
    run_instr(ADDS_R1, 4'b0110, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_cycles !== 4 || o_rw_cyc !== 3 || o_rw !== 1) begin
      n_bad++;
      $display("FAIL adds_timing: cycles %0d rw_cyc %0d rw %0d required 4 3 1",
               o_cycles, o_rw_cyc, o_rw);
    end
    n_cmp++;
    if (o_aluc !== 2'b00) begin
      n_bad++; $display("FAIL adds_aluctl: got %b required 00", o_aluc);
    end
    n_cmp++;
    if (InstrCnt !== 32'd1) begin
      n_bad++; $display("FAIL adds_instrcnt: got %0d required 1", InstrCnt);
    end
    predict(BCS_I, 4'h0, 0, 0);
    run_instr(BCS_I, 4'h0, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_pcw !== 2) begin
      n_bad++; $display("FAIL adds_flag_c: pcwrites %0d required 2", o_pcw);
    end
    predict(BVS_I, 4'h0, 0, 0);
    run_instr(BVS_I, 4'h0, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_pcw !== 1) begin
      n_bad++; $display("FAIL adds_flag_v: pcwrites %0d required 1", o_pcw);
    end
  endtask

  task automatic test_branch();
    do_reset();
    predict(BEQ_I, 4'h0, 0, 0);
    run_instr(BEQ_I, 4'h0, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_cycles !== 3 || o_pcw !== 1 || o_ret !== 1) begin
      n_bad++;
      $display("FAIL beq_untaken: cycles %0d pcw %0d ret %0d required 3 1 1",
               o_cycles, o_pcw, o_ret);
    end
    predict(ADDS_R1, 4'b0100, 0, 0);
    run_instr(ADDS_R1, 4'b0100, 0, 0, 0);
    commit();
    predict(BEQ_I, 4'h0, 1, 0);
    run_instr(BEQ_I, 4'h0, 1, 0, 0);
    commit();
    n_cmp++;
    if (o_cycles !== 4 || o_pcw !== 2) begin
      n_bad++;
      $display("FAIL beq_taken: cycles %0d pcw %0d required 4 2",
               o_cycles, o_pcw);
    end
  endtask

  task automatic test_ldr_waits();
    do_reset();
    predict(LDR_I, 4'h0, 2, 3);
    run_instr(LDR_I, 4'h0, 2, 3, 1);
    commit();
    n_cmp++;
    if (o_cycles !== 10) begin
      n_bad++; $display("FAIL ldr_wait_cycles: got %0d required 10", o_cycles);
    end
    n_cmp++;
    if (o_irw !== 1 || o_irw_cyc !== 2) begin
      n_bad++;
      $display("FAIL ldr_irwrite: count %0d at %0d required 1 at 2",
               o_irw, o_irw_cyc);
    end
    n_cmp++;
    if (o_rw !== 1 || o_rw_cyc !== 9) begin
      n_bad++;
      $display("FAIL ldr_regwrite: count %0d at %0d required 1 at 9",
               o_rw, o_rw_cyc);
    end
  endtask

  task automatic test_str_pred();
    do_reset();
    predict(ADDS_R1, 4'b0100, 0, 0);
    run_instr(ADDS_R1, 4'b0100, 0, 0, 0);
    commit();
    predict(STR_NE, 4'h0, 0, 3);
    run_instr(STR_NE, 4'h0, 0, 3, 1);
    commit();
    n_cmp++;
    if (o_mw !== 0) begin
      n_bad++; $display("FAIL str_ne_memwrite: got %0d required 0", o_mw);
    end
    n_cmp++;
    if (o_cycles !== 7 || o_ret !== 1) begin
      n_bad++;
      $display("FAIL str_ne_wait: cycles %0d ret %0d required 7 1",
               o_cycles, o_ret);
    end
  endtask

  task automatic test_cmp_undef();
    do_reset();
    predict(CMP_I, 4'b1000, 0, 0);
    run_instr(CMP_I, 4'b1000, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_cycles !== 3 || o_rw !== 0 || o_ret !== 1 || o_aluc !== 2'b01) begin
      n_bad++;
      $display("FAIL cmp_exec: cyc %0d rw %0d ret %0d alu %b required 3 0 1 01",
               o_cycles, o_rw, o_ret, o_aluc);
    end
    predict(BMI_I, 4'h0, 0, 0);
    run_instr(BMI_I, 4'h0, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_pcw !== 2) begin
      n_bad++; $display("FAIL cmp_flags_n: pcwrites %0d required 2", o_pcw);
    end
    predict(OP11_I, 4'h0, 0, 0);
    run_instr(OP11_I, 4'h0, 0, 0, 0);
    commit();
    n_cmp++;
    if (o_undef !== 1 || o_ret !== 0 || o_cycles !== 2) begin
      n_bad++;
      $display("FAIL op11_undef: undef %0d ret %0d cyc %0d required 1 0 2",
               o_undef, o_ret, o_cycles);
    end
    n_cmp++;
    if (InstrCnt !== 32'd2) begin
      n_bad++; $display("FAIL op11_instrcnt: got %0d required 2", InstrCnt);
    end
  endtask

  task automatic test_nowait_nocmp();
    int rets = 0;
    int ret_cyc = -1;
    int rws = 0;
    do_reset();
    Instr = CMP_I;
    MemReady = 1'b0;
    #1;
    n_cmp++;
    if (x_IRWrite !== 1'b1) begin
      n_bad++; $display("FAIL nowait_fetch: irwrite %b required 1", x_IRWrite);
    end
    tick();
    #1;
    n_cmp++;
    if (x_Undef !== 1'b1 || x_InstrRet !== 1'b0) begin
      n_bad++;
      $display("FAIL nocmp_undef: undef %b ret %b required 1 0",
               x_Undef, x_InstrRet);
    end
    tick();
    Instr = ADD_R2;
    #1;
    n_cmp++;
    if (x_InstrCnt !== 32'd0) begin
      n_bad++; $display("FAIL nocmp_instrcnt: got %0d required 0", x_InstrCnt);
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      if (x_RegWrite) rws++;
      if (x_InstrRet) begin rets++; ret_cyc = c; end
      tick();
    end
    n_cmp++;
    if (rets !== 1 || ret_cyc !== 3 || rws !== 1) begin
      n_bad++;
      $display("FAIL nowait_add: ret %0d at %0d rw %0d required 1 at 3, 1",
               rets, ret_cyc, rws);
    end
    n_cmp++;
    if (x_InstrCnt !== 32'd1) begin
      n_bad++; $display("FAIL nowait_instrcnt: got %0d required 1", x_InstrCnt);
    end
  endtask

  function automatic logic [19:0] gen_instr();
    logic [3:0] cond = 4'($urandom);
    logic [1:0] op = 2'($urandom);
    logic [5:0] funct = 6'($urandom);
    logic [7:0] lo = 8'($urandom);
    logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    if ($urandom_range(0, 2) == 0) cond = 4'hE;
    if (op == 2'b00 && $urandom_range(0, 4) != 0)
      funct[4:1] = cmds[$urandom_range(0, 4)];
    return {cond, op, funct, lo};
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [19:0] ins = gen_instr();
      logic [3:0]  af = 4'($urandom);
      int wf = $urandom_range(0, 3);
      int wm = $urandom_range(0, 3);
      predict(ins, af, wf, wm);
      run_instr(ins, af, wf, wm, e_mem);
      commit();
      n_cmp++;
      if (o_timeout || o_cycles !== e_cycles) begin
        n_bad++;
        $display("FAIL rnd_cycles #%0d ins %h: got %0d required %0d",
                 i, ins, o_cycles, e_cycles);
      end
      n_cmp++;
      if (o_irw !== 1 || o_irw_cyc !== wf) begin
        n_bad++;
        $display("FAIL rnd_irwrite #%0d: %0d at %0d required 1 at %0d",
                 i, o_irw, o_irw_cyc, wf);
      end
      n_cmp++;
      if (o_rw !== e_rw || o_mw !== e_mw || o_pcw !== e_pcw) begin
        n_bad++;
        $display("FAIL rnd_writes #%0d ins %h: rw/mw/pcw %0d %0d %0d required %0d %0d %0d",
                 i, ins, o_rw, o_mw, o_pcw, e_rw, e_mw, e_pcw);
      end
      n_cmp++;
      if (o_undef !== e_undef || o_ret !== e_ret) begin
        n_bad++;
        $display("FAIL rnd_undef_ret #%0d ins %h: %0d %0d required %0d %0d",
                 i, ins, o_undef, o_ret, e_undef, e_ret);
      end
      if (e_alu_chk) begin
        n_cmp++;
        if (o_aluc !== e_aluc || o_srcb !== e_srcb) begin
          n_bad++;
          $display("FAIL rnd_alu #%0d ins %h: ctl %b srcb %b required %b %b",
                   i, ins, o_aluc, o_srcb, e_aluc, e_srcb);
        end
      end
      n_cmp++;
      if (InstrCnt !== 32'(m_instrs) || CycleCnt !== 32'(m_cycles)) begin
        n_bad++;
        $display("FAIL rnd_counters #%0d: instr %0d cyc %0d required %0d %0d",
                 i, InstrCnt, CycleCnt, m_instrs, m_cycles);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_adds();
    test_branch();
    test_ldr_waits();
    test_str_pred();
    test_cmp_undef();
    test_nowait_nocmp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
